// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream, packs it big-endian into 32-bit words,
// writes them to instruction memory at consecutive word addresses from 0, and
// holds the MIPS core in reset until the whole program has been written.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,       // asynchronous, active low
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              abort,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Largest legal word_count: the whole memory, 2^ADDR_W words.
   localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic start_ok;
   logic last_word;

   // A start request is only honoured for 1..2^ADDR_W words.
   assign start_ok = (word_count != '0) && (word_count <= MAX_WORDS);

   // The word being written is the last one when its address equals count-1.
   // Comparing against the address avoids a separate written-words counter.
   assign last_word = ({1'b0, addr_q} == (count_q - COUNT_ONE));

   // State and datapath registers; reset abandons any load immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         addr_q     <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Next-state and datapath update for the load sequencer.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      addr_d     = addr_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      done_d     = done_q;
      err_d      = err_q;

      case (state_q)
         IDLE, DONE: begin
            // abort has no meaning here; only start is looked at.
            if (start) begin
               if (start_ok) begin
                  count_d    = word_count;
                  addr_d     = '0;
                  byte_idx_d = '0;
                  word_d     = '0;
                  done_d     = 1'b0;
                  err_d      = 1'b0;
                  state_d    = LOAD;
               end else begin
                  err_d   = 1'b1;
                  done_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end

         LOAD: begin
            // abort wins over a byte arriving in the same cycle.
            if (abort) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (s_valid) begin
               // Shifting left places the first byte in [31:24] after four.
               word_d     = {word_q[23:0], s_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = WRITE;
               end
            end
         end

         WRITE: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               // Address wraps to 0 after a full-memory load; harmless in DONE.
               addr_d     = addr_q + ADDR_ONE;
               byte_idx_d = '0;
               if (last_word) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = LOAD;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from the current state; an abort during WRITE
   // cancels that cycle's write strobe.
   always_comb begin
      s_ready    = (state_q == LOAD);
      imem_we    = (state_q == WRITE) && !abort;
      imem_addr  = addr_q;
      imem_wdata = word_q;
      cpu_reset  = (state_q != DONE);
      busy       = (state_q == LOAD) || (state_q == WRITE);
      done       = done_q;
      err        = err_q;
   end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: start-validation table, directed corner-case
// sequences and randomized loads checked against a byte-queue model.
module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W:0]   word_count;
   logic              abort;
   logic [7:0]        s_data;
   logic              s_valid;
   logic              s_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   logic [7:0]        tx_q[$];
   logic [7:0]        pat_q[$];

   typedef struct {
      int wc;
      bit ok;
   } start_vec_t;

   start_vec_t tbl[7];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .abort      (abort),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Record every memory write, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset && imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
         $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_writes();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic do_start(input int wc);
      start      = 1'b1;
      word_count = wc[ADDR_W:0];
      step();
      start      = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_s_ready"}, 32'(s_ready), 32'd0);
      check({pfx, "_imem_we"}, 32'(imem_we), 32'd0);
      check({pfx, "_imem_addr"}, 32'(imem_addr), 32'd0);
      check({pfx, "_imem_wdata"}, imem_wdata, 32'd0);
      check({pfx, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({pfx, "_busy"}, 32'(busy), 32'd0);
      check({pfx, "_done"}, 32'(done), 32'd0);
      check({pfx, "_err"}, 32'(err), 32'd0);
   endtask

   // Present tx_q bytes; mode 0 always valid, 1 toggling, 2 random valid
   // plus random start pulses that the loader must ignore.
   task automatic feed(input string name, input int mode, input int max_cycles);
      int n;
      bit acc;
      n = 0;
      while (tx_q.size() > 0) begin
         if (n >= max_cycles) begin
            check({name, "_feed_timeout"}, 32'(tx_q.size()), 32'd0);
            tx_q.delete();
            break;
         end
         case (mode)
            0:       s_valid = 1'b1;
            1:       s_valid = ((n % 2) == 0);
            default: s_valid = 1'($urandom_range(0, 1));
         endcase
         s_data = tx_q[0];
         if (mode == 2 && $urandom_range(0, 3) == 0) begin
            start      = 1'b1;
            word_count = (ADDR_W+1)'($urandom_range(0, 511));
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         acc = s_valid && s_ready;
         step();
         if (acc) void'(tx_q.pop_front());
         n++;
      end
      s_valid = 1'b0;
      start   = 1'b0;
   endtask

   // Full load of pat_q as wc words; expected writes come straight from
   // the byte list: word i = bytes 4i..4i+3 big-endian, at address i.
   task automatic run_load(input string name, input int wc, input int mode);
      int n;
      logic [31:0] exp_w;
      clear_writes();
      tx_q = pat_q;
      do_start(wc);
      check({name, "_busy_after_start"}, 32'(busy), 32'd1);
      check({name, "_err_after_start"}, 32'(err), 32'd0);
      feed(name, mode, 20 * pat_q.size() + 50);
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      check({name, "_busy_end"}, 32'(busy), 32'd0);
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
      check({name, "_err"}, 32'(err), 32'd0);
      check({name, "_nwrites"}, 32'(wr_data.size()), 32'(wc));
      for (int i = 0; i < wc && i < wr_data.size(); i++) begin
         exp_w = {pat_q[4*i], pat_q[4*i+1], pat_q[4*i+2], pat_q[4*i+3]};
         check($sformatf("%s_w%0d_addr", name, i), 32'(wr_addr[i]), 32'(i));
         check($sformatf("%s_w%0d_data", name, i), wr_data[i], exp_w);
      end
   endtask

   task automatic random_pattern(input int wc);
      pat_q.delete();
      for (int i = 0; i < 4 * wc; i++) pat_q.push_back(8'($urandom_range(0, 255)));
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      s_valid    = 1'b0;
      s_data     = 8'h00;
      word_count = '0;

      // Reset state
      #1;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Start validation table: {word_count, accepted}
      tbl[0] = '{0, 1'b0};
      tbl[1] = '{1, 1'b1};
      tbl[2] = '{256, 1'b1};
      tbl[3] = '{257, 1'b0};
      tbl[4] = '{511, 1'b0};
      tbl[5] = '{128, 1'b1};
      tbl[6] = '{255, 1'b1};
      for (int i = 0; i < 7; i++) begin
         clear_writes();
         do_start(tbl[i].wc);
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].ok));
         check($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].ok));
         check($sformatf("tbl%0d_err", i), 32'(err), 32'(!tbl[i].ok));
         check($sformatf("tbl%0d_done", i), 32'(done), 32'd0);
         check($sformatf("tbl%0d_cpu_reset", i), 32'(cpu_reset), 32'd1);
         if (tbl[i].ok) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            check($sformatf("tbl%0d_abort_busy", i), 32'(busy), 32'd0);
            check($sformatf("tbl%0d_abort_err", i), 32'(err), 32'd1);
         end
         check($sformatf("tbl%0d_nwrites", i), 32'(wr_data.size()), 32'd0);
      end

      // Two-word load with a fixed program
      pat_q = '{8'h20, 8'h01, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
      run_load("load2", 2, 0);

      // Bad start from DONE
      clear_writes();
      do_start(0);
      check("done_bad_start_err", 32'(err), 32'd1);
      check("done_bad_start_done", 32'(done), 32'd0);
      check("done_bad_start_cpu_reset", 32'(cpu_reset), 32'd1);
      check("done_bad_start_busy", 32'(busy), 32'd0);
      repeat (3) step();
      check("done_bad_start_nwrites", 32'(wr_data.size()), 32'd0);

      // One word with s_valid toggling every cycle
      pat_q = '{8'h00, 8'h41, 8'h20, 8'h2A};
      run_load("toggle", 1, 1);

      // Abort together with the 3rd byte of word 1
      clear_writes();
      do_start(2);
      tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      feed("abort_load", 0, 100);
      s_valid = 1'b1;
      s_data  = 8'h77;
      abort   = 1'b1;
      @(negedge clk);
      check("abort_load_ready_same_cycle", 32'(s_ready), 32'd1);
      step();
      abort   = 1'b0;
      s_valid = 1'b0;
      check("abort_load_busy", 32'(busy), 32'd0);
      check("abort_load_err", 32'(err), 32'd1);
      check("abort_load_cpu_reset", 32'(cpu_reset), 32'd1);
      check("abort_load_done", 32'(done), 32'd0);
      repeat (5) step();
      check("abort_load_nwrites", 32'(wr_data.size()), 32'd1);
      if (wr_data.size() > 0) begin
         check("abort_load_w0_data", wr_data[0], 32'h11223344);
         check("abort_load_w0_addr", 32'(wr_addr[0]), 32'd0);
      end

      // Abort during the WRITE cycle suppresses the strobe
      clear_writes();
      do_start(2);
      tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      feed("abort_write", 0, 100);
      abort = 1'b1;
      @(negedge clk);
      check("abort_write_in_write", 32'(busy && !s_ready), 32'd1);
      check("abort_write_we", 32'(imem_we), 32'd0);
      step();
      abort = 1'b0;
      check("abort_write_busy", 32'(busy), 32'd0);
      check("abort_write_err", 32'(err), 32'd1);
      repeat (3) step();
      check("abort_write_nwrites", 32'(wr_data.size()), 32'd0);

      // Reset asserted during the 6th byte
      clear_writes();
      do_start(2);
      tx_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      feed("rst_mid", 0, 100);
      s_valid = 1'b1;
      s_data  = 8'hA6;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      s_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mid_nwrites", 32'(wr_data.size()), 32'd1);
      reset = 1'b1;
      step();
      check_reset_outputs("rst_release");
      random_pattern(1);
      run_load("after_rst", 1, 2);

      // Randomized loads with random valid patterns
      for (int r = 0; r < 4; r++) begin
         int wc;
         wc = $urandom_range(1, 20);
         random_pattern(wc);
         run_load($sformatf("rand%0d", r), wc, $urandom_range(0, 2));
      end

      // Whole memory
      random_pattern(256);
      run_load("full", 256, 0);
      if (wr_addr.size() > 0) check("full_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of instruction memory.
REQ-002 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a program load.
REQ-005 SHALL have port word_count, input, ADDR_W+1, number of 32-bit words to load, sampled on accepted start.
REQ-006 SHALL have port abort, input, 1, cancels an in-progress load.
REQ-007 SHALL have port s_data, input, 8, program byte stream.
REQ-008 SHALL have port s_valid, input, 1, s_data valid.
REQ-009 SHALL have port s_ready, output, 1, loader accepts byte this cycle.
REQ-010 SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-011 SHALL have port imem_addr, output, ADDR_W, instruction-memory word address.
REQ-012 SHALL have port imem_wdata, output, 32, instruction word to write.
REQ-013 SHALL have port cpu_reset, output, 1, active-high reset driven to the MIPS core.
REQ-014 SHALL have port busy, output, 1, load in progress.
REQ-015 SHALL have port done, output, 1, last load completed successfully.
REQ-016 SHALL have port err, output, 1, last start or load failed.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: start=1 with 1 <= word_count <= 2^ADDR_W SHALL latch word_count, clear addr, byte index, done and err, and go to LOAD next cycle.
REQ-019 IDLE or DONE: start=1 with word_count=0 or > 2^ADDR_W SHALL set err=1, clear done, and stay in or return to IDLE.
REQ-020 LOAD: s_ready SHALL be 1; a byte transfers only when s_valid and s_ready are both 1.
REQ-021 Bytes SHALL assemble big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-022 The 4th byte transfer SHALL move FSM to WRITE; imem_we=1 for exactly one cycle in WRITE, with imem_wdata the assembled word and imem_addr the current word address.
REQ-023 In WRITE s_ready SHALL be 0; no byte is consumed.
REQ-024 After WRITE, address SHALL increment by 1; if words written equals latched count, go to DONE, else back to LOAD with byte index 0.
REQ-025 With word_count=2^ADDR_W the final write SHALL use address 2^ADDR_W-1; address wrap after the last write is not observable.
REQ-026 start SHALL be ignored in LOAD and WRITE.
REQ-027 abort=1 in LOAD or WRITE SHALL go to IDLE next cycle, set err=1, suppress any pending imem_we, and keep cpu_reset=1; abort has priority over a simultaneous byte transfer. abort is ignored in IDLE and DONE.
REQ-028 DONE: done=1, cpu_reset=0 (CPU runs from address 0); start from DONE follows REQ-018/REQ-019.
REQ-029 cpu_reset SHALL be 1 in IDLE, LOAD and WRITE, 0 only in DONE.
REQ-030 busy SHALL be 1 exactly in LOAD and WRITE.
REQ-031 imem_we SHALL be 0 in every state except WRITE.

Reset
REQ-032 While reset=0: state IDLE, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, done=0, err=0; all counters 0.
REQ-033 reset asserted mid-load SHALL abandon the load immediately (asynchronously); no write occurs after assertion.

Verification
REQ-034 Load 2 words: start, word_count=2, bytes 20 01 00 0A 00 00 00 00 -> writes 0x2001000A@0, 0x00000000@1, done=1, cpu_reset=0.
REQ-035 s_valid toggled 1/0 every cycle during a 1-word load of 0x0041202A -> single write 0x0041202A@0, no byte lost or duplicated.
REQ-036 start with word_count=0 -> err=1, done=0, no imem_we, cpu_reset stays 1.
REQ-037 abort on the same cycle as the 3rd byte of word 1 -> IDLE, err=1, word 0 written, no further writes, cpu_reset=1.
REQ-038 reset=0 during the 6th byte, then released -> all outputs at REQ-032 values; a new 1-word load then succeeds at address 0.
REQ-039 Full load with word_count=2^ADDR_W (256 for default) -> last write at address 255, done=1.
